// File: rtl/riscv_pkg.sv
// Shared constants for the 8-bit RISC core register file and its scoreboard.
package riscv_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned NUM_REGS = 8;
  localparam logic [2:0]  REG_ZERO = 3'd0;

endpackage

// File: rtl/regfile_wb_pend_counter.sv
// Per-register count of writes in flight; inc and dec together leave it unchanged.
module pend_counter #(
  parameter int unsigned CNT_W = riscv_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  // A write-back with nothing outstanding is an error even if an issue coincides.
  assign underflow = dec && (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// Architectural register file with write-through bypass and a pending-write
// scoreboard that raises the decode stall for hazards bypass cannot cover.
module regfile_wb
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_W = riscv_pkg::DATA_W,
  parameter int unsigned ADDR_W = riscv_pkg::ADDR_W,
  parameter int unsigned CNT_W  = riscv_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs1_use,
  input  logic              rs2_use,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              err
);

  localparam int unsigned NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] RZ = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  pend [NREG];
  logic [NREG-1:0]   wb_hit;
  logic [NREG-1:0]   issue_hit;
  logic [NREG-1:0]   uflow;
  logic [NREG-1:0]   busy;
  logic              issue_full;
  logic              issue_acc;
  logic              wb_wr;

  assign wb_wr = wb_en && (wb_rd != RZ);

  always_comb begin
    wb_hit = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      wb_hit[i] = wb_en && (wb_rd == ADDR_W'(i));
    end
  end

  always_comb begin
    issue_hit = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      issue_hit[i] = issue_acc && (issue_rd == ADDR_W'(i));
    end
  end

  assign pend[0]  = '0;
  assign busy[0]  = 1'b0;
  assign uflow[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_pend
    pend_counter #(.CNT_W(CNT_W)) u_pend (
      .clk       (clk),
      .rst       (rst),
      .inc       (issue_hit[g]),
      .dec       (wb_hit[g]),
      .count     (pend[g]),
      .underflow (uflow[g])
    );
    // The last outstanding write landing this cycle is served by bypass.
    assign busy[g] = (pend[g] > CNT_W'(1)) || ((pend[g] == CNT_W'(1)) && !wb_hit[g]);
  end

  assign issue_full = issue_en && (issue_rd != RZ) && (pend[issue_rd] == '1) && !wb_hit[issue_rd];
  assign stall      = (rs1_use && busy[rs1_addr]) || (rs2_use && busy[rs2_addr]) || issue_full;
  assign issue_acc  = issue_en && !stall && (issue_rd != RZ);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_wr) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (|uflow) begin
      err <= 1'b1;
    end
  end

  always_comb begin
    rs1_data = (wb_wr && (wb_rd == rs1_addr)) ? wb_data : regs[rs1_addr];
    rs2_data = (wb_wr && (wb_rd == rs2_addr)) ? wb_data : regs[rs2_addr];
    dbg_data = regs[dbg_addr];
  end

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: a behavioural model queues expected outputs per cycle.
module tb_regfile_wb;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_en;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic          rs1_use, rs2_use;
  logic [DW-1:0] rs1_data, rs2_data;
  logic          issue_en;
  logic [AW-1:0] issue_rd;
  logic          stall;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic          err;

  always #5 clk = ~clk;

  regfile_wb #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_use(rs1_use), .rs2_use(rs2_use),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .issue_en(issue_en), .issue_rd(issue_rd),
    .stall(stall), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .err(err)
  );

  typedef struct {
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [DW-1:0] dbg;
    logic          stall;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [DW-1:0] m_regs [8];
  int            m_pend [8];
  logic          m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wb_en && wb_rd == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return (m_pend[a] > 1) || (m_pend[a] == 1 && !(wb_en && wb_rd == a));
  endfunction

  function automatic logic m_stall();
    logic full;
    full = issue_en && issue_rd != 0 && m_pend[issue_rd] == 3 && !(wb_en && wb_rd == issue_rd);
    return (rs1_use && m_busy(rs1_addr)) || (rs2_use && m_busy(rs2_addr)) || full;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic idle();
    rst = 0; wb_en = 0; wb_rd = '0; wb_data = '0;
    rs1_addr = '0; rs2_addr = '0; rs1_use = 0; rs2_use = 0;
    issue_en = 0; issue_rd = '0; dbg_addr = '0;
  endtask

  // One clock: queue expectations from the model, compare mid-cycle, then advance the model.
  task automatic cycle();
    exp_t e, o;
    logic st;
    st      = m_stall();
    e.rs1   = m_read(rs1_addr);
    e.rs2   = m_read(rs2_addr);
    e.dbg   = (dbg_addr == 0) ? '0 : m_regs[dbg_addr];
    e.stall = st;
    e.err   = m_err;
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    check("rs1_data", 32'(rs1_data), 32'(o.rs1));
    check("rs2_data", 32'(rs2_data), 32'(o.rs2));
    check("dbg_data", 32'(dbg_data), 32'(o.dbg));
    check("stall", 32'(stall), 32'(o.stall));
    check("err", 32'(err), 32'(o.err));
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
      for (int r = 1; r < 8; r++) begin
        logic acc, hit;
        acc = issue_en && !st && issue_rd == r;
        hit = wb_en && wb_rd == r;
        if (hit && m_pend[r] == 0) m_err = 1'b1;
        if (acc && !hit) m_pend[r]++;
        else if (hit && !acc && m_pend[r] > 0) m_pend[r]--;
      end
    end
    #1;
  endtask

  initial begin
    idle();
    m_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // reset state
    dbg_addr = 3; rs1_addr = 3; rs2_addr = 5;
    cycle();

    // write r3 with same-cycle bypass, then visible on debug port
    wb_en = 1; wb_rd = 3; wb_data = 8'hA5; rs1_addr = 3; dbg_addr = 3;
    cycle();
    idle(); dbg_addr = 3; rs2_addr = 3;
    cycle();

    // r0 stays zero and is never tracked
    wb_en = 1; wb_rd = 0; wb_data = 8'hFF; issue_en = 1; issue_rd = 0;
    rs1_addr = 0; rs1_use = 1; dbg_addr = 0;
    cycle();
    idle(); rs1_use = 1;
    cycle();

    // RAW stall on r2 until its write-back lands
    issue_en = 1; issue_rd = 2;
    cycle();
    idle(); rs1_addr = 2; rs1_use = 1;
    cycle();
    cycle();
    wb_en = 1; wb_rd = 2; wb_data = 8'h3C;
    cycle();
    idle(); rs1_addr = 2; rs1_use = 1; dbg_addr = 2;
    cycle();

    // three in flight on r5, fourth blocked, issue+wb holds at 3
    idle(); issue_en = 1; issue_rd = 5;
    repeat (4) cycle();
    wb_en = 1; wb_rd = 5; wb_data = 8'h11;
    cycle();
    idle(); rs2_addr = 5; rs2_use = 1;
    cycle();
    wb_en = 1; wb_rd = 5;
    for (int k = 0; k < 4; k++) begin
      wb_data = 8'(8'h50 + k);
      cycle();
    end

    // underflow on r4: still written, err sticky
    idle(); wb_en = 1; wb_rd = 4; wb_data = 8'h77; dbg_addr = 4;
    cycle();
    idle(); dbg_addr = 4;
    repeat (2) cycle();

    // reset mid-flight drops pending state and err
    idle(); issue_en = 1; issue_rd = 1;
    repeat (2) cycle();
    rst = 1;
    cycle();
    idle(); rs1_addr = 1; rs1_use = 1; issue_en = 1; issue_rd = 1; dbg_addr = 4;
    cycle();

    // randomised traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      rst      = ($urandom_range(0, 99) < 3);
      wb_en    = ($urandom_range(0, 99) < 35);
      wb_rd    = AW'($urandom_range(0, 7));
      wb_data  = DW'($urandom);
      issue_en = ($urandom_range(0, 99) < 45);
      issue_rd = AW'($urandom_range(0, 7));
      rs1_addr = AW'($urandom_range(0, 7));
      rs2_addr = AW'($urandom_range(0, 7));
      rs1_use  = $urandom_range(0, 1) == 1;
      rs2_use  = $urandom_range(0, 1) == 1;
      dbg_addr = AW'($urandom_range(0, 7));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Architectural register file for the 8-bit RISC core: the receiving end of the write-back path driven by the MEM/WB pipeline register. It holds eight 8-bit registers with r0 hardwired to zero and serves two combinational read ports to the ID stage, with write-through bypass. A per-register pending-write scoreboard produces the decode-stage stall for read-after-write hazards that bypass cannot cover.

## Interface
Parameters:
- DATA_W, 8, register width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- CNT_W, 2, pending-write counter width (max 3 writes in flight per register)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_en  in  1  write-back enable (regwrite from MEM/WB)
- wb_rd  in  ADDR_W  write-back destination register
- wb_data  in  DATA_W  write-back value (MEM/WB mux output)
- rs1_addr, rs2_addr  in  ADDR_W  ID-stage source registers
- rs1_use, rs2_use  in  1  instruction actually reads rs1 / rs2
- rs1_data, rs2_data  out  DATA_W  read data, combinational
- issue_en  in  1  ID stage requests issue of an instruction that writes issue_rd
- issue_rd  in  ADDR_W  destination of the issuing instruction
- stall  out  1  hold ID stage / suppress issue this cycle
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data, no bypass
- err  out  1  sticky scoreboard error

## Operation
- Write: wb_en && wb_rd != 0 -> reg[wb_rd] <= wb_data at the clock edge. Writes to r0 are discarded.
- Read: rsN_data = 0 if rsN_addr == 0. Otherwise it equals wb_data if wb_en && wb_rd == rsN_addr, else reg[rsN_addr]. dbg_data = reg[dbg_addr], with r0 reading 0.
- Scoreboard: pend[r] per register r = 1..7, CNT_W bits; r0 is never tracked.
  - issue_acc = issue_en && !stall && issue_rd != 0
  - wb_hit(r) = wb_en && wb_rd == r
  - Per register: issue_acc only -> +1; wb_hit only -> -1; both on the same register -> unchanged.
- busy(a) = pend[a] > 1, or pend[a] == 1 && !wb_hit(a). The final landing write is covered by bypass.
- stall = (rs1_use && busy(rs1_addr)) || (rs2_use && busy(rs2_addr)) || (issue_en && issue_rd != 0 && pend[issue_rd] == 3 && !wb_hit(issue_rd)).
- Error cases, each of which sets err until reset:
  - Underflow: wb_hit(r) with pend[r] == 0. The write is still performed and pend stays 0.
  - Overflow cannot occur, because the third clause of stall blocks it.

## Timing
- Reset values: all registers 0, all pend 0, err 0. Consequently rs1_data, rs2_data and dbg_data read 0 and stall is 0 on the cycle after rst.
- rst takes priority over wb_en and issue_en in the same cycle. In-flight pending state is dropped; the pipeline registers reset in the same cycle.
- Write latency: a value written at edge N is visible from reg[] after edge N. It is also visible in cycle N itself via bypass on rsN_data, but not on dbg_data.
- stall is purely combinational from the current inputs and pend. The scoreboard update uses the stall value of the same cycle.
- pend reaching 0 at edge N means stall for that register deasserts in the cycle after N. In cycle N itself it has already deasserted when pend == 1 and the write lands.

## Structure
- Shared package `riscv_pkg`: DATA_W, ADDR_W, CNT_W, NUM_REGS = 8, REG_ZERO = 3'd0.
- One sub-module, `pend_counter`: a CNT_W up/down counter with inc, dec, simultaneous-hold rule and an underflow flag. It is instantiated for r1..r7.
- Top level holds the register array, read/bypass muxes, stall logic and err latch.

## Test plan
- Reset then read: rst for 2 cycles -> rs1_data = rs2_data = dbg_data = 0x00, stall = 0, err = 0.
- Write and bypass: wb_en=1, wb_rd=3, wb_data=0xA5, rs1_addr=3 in the same cycle -> rs1_data = 0xA5 in that cycle, and dbg_data(3) = 0xA5 from the next cycle.
- r0 immutability: wb_en=1, wb_rd=0, wb_data=0xFF; issue_rd=0 -> reg0 reads 0x00, no pend change, stall = 0.
- RAW stall: issue r2, then rs1_addr=2 with rs1_use=1 -> stall = 1 until the wb_en/wb_rd=2 cycle, where stall = 0 and rs1_data = wb_data.
- Multiple in flight: three issues to r5 with no write-back -> a 4th issue_en to r5 gives stall = 1 and pend stays 3. A simultaneous issue and wb to r5 leaves pend = 3.
- Underflow and reset: wb_en to r4 with pend=0 -> data written and err = 1 sticky. Then rst mid-flight with pend[1]=2 -> pend cleared, err = 0, stall = 0.
